// File: rtl/cmd_dispatch.sv
// Command FIFO consumer: pops one command, checks it, runs one burst, pushes one response.
// Optional WAIT watchdog enabled by defining CMD_DISPATCH_TIMEOUT_EN.
module cmd_dispatch #(
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 4,
  parameter int DATA_BYTES = 8,
  parameter int TO_CYCLES  = 1024,
  localparam int CMD_W     = ID_W + 1 + ADDR_W + 8,
  localparam int RESP_W    = ID_W + 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_fifo_empty,
  output logic              cmd_pop_req,
  input  logic              cmd_pop_ack,
  input  logic [CMD_W-1:0]  cmd_pop_struct,
  output logic              resp_push_req,
  input  logic              resp_push_ack,
  output logic [RESP_W-1:0] resp_push_struct,
  output logic              burst_start,
  output logic              burst_op,
  output logic [ADDR_W-1:0] burst_addr,
  output logic [7:0]        burst_len,
  input  logic              burst_done,
  input  logic [1:0]        burst_resp,
  output logic              busy,
  output logic [15:0]       cmd_count
);

  typedef enum logic [2:0] {
    IDLE, POP, POP_LOW, CHECK, ISSUE, WAIT, PUSH, PUSH_LOW
  } state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   cmd_id;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic [1:0]        status;
  logic              stale;
  logic              pop_hit, push_hit, to_hit;

  // Legality: beat-aligned start and burst stays inside one 4KB page.
  logic [ADDR_W:0] beats, bytes, end_off;
  logic            crosses, misalign, check_ok;

  assign beats    = (ADDR_W+1)'(cmd_len) + (ADDR_W+1)'(1);
  assign bytes    = beats * (ADDR_W+1)'(DATA_BYTES);
  assign end_off  = (ADDR_W+1)'(cmd_addr[11:0]) + bytes;
  assign crosses  = end_off > (ADDR_W+1)'(4096);
  assign misalign = |(cmd_addr & ADDR_W'(DATA_BYTES-1));
  assign check_ok = !misalign && !crosses;

  assign pop_hit  = (state == POP)  && cmd_pop_ack   && !stale;
  assign push_hit = (state == PUSH) && resp_push_ack && !stale;

`ifdef CMD_DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TO_CYCLES + 1);
  logic [WD_W-1:0] wdog;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             wdog <= '0;
    else if (state != WAIT)  wdog <= '0;
    else                     wdog <= wdog + WD_W'(1);
  end

  assign to_hit = (state == WAIT) && (wdog == WD_W'(TO_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (!cmd_fifo_empty) state_nx = POP;
      POP:      if (pop_hit) state_nx = POP_LOW;
      POP_LOW:  if (!cmd_pop_ack) state_nx = CHECK;
      CHECK:    state_nx = check_ok ? ISSUE : PUSH;
      ISSUE:    state_nx = WAIT;
      WAIT:     if (burst_done || to_hit) state_nx = PUSH;
      PUSH:     if (push_hit) state_nx = PUSH_LOW;
      PUSH_LOW: if (!resp_push_ack) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // An ack already high when a handshake opens is stale until seen low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stale <= 1'b0;
    else if (state_nx == POP && state != POP)
      stale <= cmd_pop_ack;
    else if (state_nx == PUSH && state != PUSH)
      stale <= resp_push_ack;
    else if ((state == POP && !cmd_pop_ack) || (state == PUSH && !resp_push_ack))
      stale <= 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_id    <= '0;
      cmd_op    <= 1'b0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      status    <= 2'b00;
      cmd_count <= '0;
    end else begin
      if (pop_hit) begin
        cmd_id   <= cmd_pop_struct[CMD_W-1 -: ID_W];
        cmd_op   <= cmd_pop_struct[ADDR_W+8];
        cmd_addr <= cmd_pop_struct[ADDR_W+7:8];
        cmd_len  <= cmd_pop_struct[7:0];
      end
      if (state == CHECK && !check_ok)  status <= 2'b10;
      else if (state == WAIT && burst_done) status <= burst_resp;
      else if (to_hit)                  status <= 2'b11;
      if (state == PUSH_LOW && !resp_push_ack) cmd_count <= cmd_count + 16'd1;
    end
  end

  assign cmd_pop_req      = (state == POP);
  assign resp_push_req    = (state == PUSH);
  assign burst_start      = (state == ISSUE);
  assign busy             = (state != IDLE);
  assign burst_op         = cmd_op;
  assign burst_addr       = cmd_addr;
  assign burst_len        = cmd_len;
  assign resp_push_struct = {cmd_id, cmd_op, status};

endmodule

// File: tb/tb_cmd_dispatch.sv
// Table-driven bench for cmd_dispatch: FIFO/burst-engine emulation with a response scoreboard.
module tb_cmd_dispatch;

  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int CMD_W  = ID_W + 1 + ADDR_W + 8;
  localparam int RESP_W = ID_W + 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic              cmd_fifo_empty;
  logic              cmd_pop_req;
  logic              cmd_pop_ack;
  logic [CMD_W-1:0]  cmd_pop_struct;
  logic              resp_push_req;
  logic              resp_push_ack;
  logic [RESP_W-1:0] resp_push_struct;
  logic              burst_start;
  logic              burst_op;
  logic [ADDR_W-1:0] burst_addr;
  logic [7:0]        burst_len;
  logic              burst_done;
  logic [1:0]        burst_resp;
  logic              busy;
  logic [15:0]       cmd_count;

  always #5 clk = ~clk;

  cmd_dispatch #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_BYTES(8),
`ifdef CMD_DISPATCH_TIMEOUT_EN
    .TO_CYCLES(16)
`else
    .TO_CYCLES(1024)
`endif
  ) dut (
    .clk(clk), .resetn(resetn), .cmd_fifo_empty(cmd_fifo_empty),
    .cmd_pop_req(cmd_pop_req), .cmd_pop_ack(cmd_pop_ack), .cmd_pop_struct(cmd_pop_struct),
    .resp_push_req(resp_push_req), .resp_push_ack(resp_push_ack),
    .resp_push_struct(resp_push_struct), .burst_start(burst_start), .burst_op(burst_op),
    .burst_addr(burst_addr), .burst_len(burst_len), .burst_done(burst_done),
    .burst_resp(burst_resp), .busy(busy), .cmd_count(cmd_count)
  );

  typedef struct {
    string       name;
    logic [3:0]  id;
    logic        op;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  bresp;
    logic        exp_burst;
    logic [1:0]  exp_status;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int n_starts = 0;
  logic [15:0] exp_cnt = '0;
  logic [RESP_W-1:0] sb[$];

  always @(negedge clk) if (burst_start === 1'b1) n_starts++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return cmd_pop_req;
      1:       return resp_push_req;
      2:       return burst_start;
      default: return busy;
    endcase
  endfunction

  task automatic wait_for(input int w, input logic lvl, input string nm);
    for (int i = 0; i < 200; i++) begin
      if (sig(w) === lvl) return;
      @(negedge clk);
    end
    chk({nm, "_timeout"}, 64'(sig(w)), 64'(lvl));
  endtask

  task automatic do_pop(input vec_t v);
    @(negedge clk);
    cmd_fifo_empty = 1'b0;
    wait_for(0, 1'b1, "pop_req");
    cmd_pop_ack    = 1'b1;
    cmd_pop_struct = {v.id, v.op, v.addr, v.len};
    cmd_fifo_empty = 1'b1;
    sb.push_back({v.id, v.op, v.exp_status});
    @(negedge clk);
    wait_for(0, 1'b0, "pop_drop");
    cmd_pop_ack    = 1'b0;
    cmd_pop_struct = '0;
  endtask

  task automatic do_burst(input vec_t v, input bit stale);
    wait_for(2, 1'b1, "burst_start");
    chk({v.name, "_addr"}, 64'(burst_addr), 64'(v.addr));
    chk({v.name, "_len"},  64'(burst_len),  64'(v.len));
    chk({v.name, "_op"},   64'(burst_op),   64'(v.op));
    repeat (3) @(negedge clk);
    chk({v.name, "_wait_busy"}, 64'(busy), 64'd1);
    chk({v.name, "_addr_hold"}, 64'(burst_addr), 64'(v.addr));
    burst_done = 1'b1;
    burst_resp = v.bresp;
    if (stale) resp_push_ack = 1'b1;
    @(negedge clk);
    burst_done = 1'b0;
    burst_resp = 2'b00;
  endtask

  task automatic do_push(input string nm, input int bp, input bit stale);
    logic [RESP_W-1:0] exp;
    wait_for(1, 1'b1, "push_req");
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd1);
      return;
    end
    exp = sb.pop_front();
    if (stale) begin
      repeat (3) @(negedge clk);
      chk({nm, "_stale_ack_ignored"}, 64'(resp_push_req), 64'd1);
      resp_push_ack = 1'b0;
      @(negedge clk);
    end
    if (bp > 0) begin
      cmd_fifo_empty = 1'b0;
      for (int c = 0; c < bp; c++) begin
        chk({nm, "_bp_req"},    64'(resp_push_req),    64'd1);
        chk({nm, "_bp_struct"}, 64'(resp_push_struct), 64'(exp));
        chk({nm, "_bp_nopop"},  64'(cmd_pop_req),      64'd0);
        @(negedge clk);
      end
      cmd_fifo_empty = 1'b1;
    end
    chk({nm, "_resp"}, 64'(resp_push_struct), 64'(exp));
    resp_push_ack = 1'b1;
    @(negedge clk);
    wait_for(1, 1'b0, "push_drop");
    resp_push_ack = 1'b0;
    exp_cnt++;
    repeat (2) @(negedge clk);
    chk({nm, "_count"}, 64'(cmd_count), 64'(exp_cnt));
    chk({nm, "_idle"},  64'(busy), 64'd0);
  endtask

  task automatic run_cmd(input vec_t v, input int bp, input bit stale);
    int s0;
    s0 = n_starts;
    do_pop(v);
    if (v.exp_burst) do_burst(v, stale);
    do_push(v.name, bp, stale);
    chk({v.name, "_starts"}, 64'(n_starts - s0), 64'(v.exp_burst));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"},   64'(busy), 64'd0);
    chk({nm, "_reqs"},   64'({cmd_pop_req, resp_push_req, burst_start}), 64'd0);
    chk({nm, "_burst"},  64'({burst_op, burst_addr, burst_len}), 64'd0);
    chk({nm, "_resp"},   64'(resp_push_struct), 64'd0);
    chk({nm, "_count"},  64'(cmd_count), 64'd0);
  endtask

  vec_t vecs[7];
  vec_t v;

  initial begin
    vecs[0] = '{"single_wr", 4'h3, 1'b1, 32'h0000_1000, 8'd3,   2'b00, 1'b1, 2'b00};
    vecs[1] = '{"cross4k",   4'h5, 1'b0, 32'h0000_0FF8, 8'd1,   2'b00, 1'b0, 2'b10};
    vecs[2] = '{"unaligned", 4'h6, 1'b1, 32'h0000_1004, 8'd0,   2'b00, 1'b0, 2'b10};
    vecs[3] = '{"exact4k",   4'h7, 1'b0, 32'h0000_2800, 8'd255, 2'b01, 1'b1, 2'b01};
    vecs[4] = '{"over4k",    4'h8, 1'b1, 32'h0000_2808, 8'd255, 2'b00, 1'b0, 2'b10};
    vecs[5] = '{"last_beat", 4'h9, 1'b0, 32'h0000_3FF8, 8'd0,   2'b11, 1'b1, 2'b11};
    vecs[6] = '{"hi_addr",   4'hF, 1'b1, 32'hFFFF_F000, 8'd0,   2'b10, 1'b1, 2'b10};

    resetn = 1'b0; cmd_fifo_empty = 1'b1; cmd_pop_ack = 1'b0; cmd_pop_struct = '0;
    resp_push_ack = 1'b0; burst_done = 1'b0; burst_resp = 2'b00;
    #1 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Main table: first entry under 20 cycles of backpressure, exact4k with a stale push ack.
    for (int i = 0; i < 7; i++)
      run_cmd(vecs[i], (i == 0) ? 20 : 0, i == 3);

    // burst_done while idle must not start anything.
    @(negedge clk);
    burst_done = 1'b1;
    @(negedge clk);
    burst_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_done_busy", 64'(busy), 64'd0);
    chk("stray_done_push", 64'(resp_push_req), 64'd0);

    // Reset in WAIT abandons the command.
    v = '{"rst_wait", 4'h2, 1'b1, 32'h0000_4000, 8'd1, 2'b00, 1'b1, 2'b00};
    do_pop(v);
    wait_for(2, 1'b1, "rst_burst_start");
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk_all_zero("rst_wait");
    sb.delete();
    exp_cnt = '0;
    @(negedge clk);
    resetn = 1'b1;
    burst_done = 1'b1;
    @(negedge clk);
    burst_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_push", 64'(resp_push_req), 64'd0);
    v = '{"after_rst", 4'hA, 1'b0, 32'h0000_5040, 8'd7, 2'b00, 1'b1, 2'b00};
    run_cmd(v, 0, 1'b0);

`ifdef CMD_DISPATCH_TIMEOUT_EN
    begin
      int waits;
      v = '{"timeout", 4'hC, 1'b1, 32'h0000_6000, 8'd0, 2'b00, 1'b1, 2'b11};
      do_pop(v);
      wait_for(2, 1'b1, "to_burst_start");
      waits = 0;
      @(negedge clk);
      while (!resp_push_req && waits < 40) begin
        waits++;
        @(negedge clk);
      end
      chk("to_wait_cycles", 64'(waits), 64'd16);
      burst_done = 1'b1;
      burst_resp = 2'b00;
      @(negedge clk);
      burst_done = 1'b0;
      do_push("timeout", 0, 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=done", total);
    $fatal(1, "bench timed out");
  end

endmodule
